// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: reset defaults,
// configuration length clamping and the fill-derived state encoding.
package seq_det_pkg;

  // Reset configuration: the legacy 5-bit "10010" detector, overlapping.
  localparam int unsigned DEF_PAT_W = 8;
  localparam logic [DEF_PAT_W-1:0] DEF_PAT = 8'b0001_0010;
  localparam int unsigned DEF_LEN = 5;
  localparam bit DEF_OVL = 1'b1;

  // Detector progress, derived from the number of valid history bits.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } det_state_e;

  // Effective length is forced into 1..max_len.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    int unsigned res;
    res = len;
    if (len == 0) begin
      res = 1;
    end else if (len > max_len) begin
      res = max_len;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   inc      : count one event this cycle
//   clr      : clear count and flag (a simultaneous inc leaves the count at 1)
//   cnt      : current count, holds at all-ones
//   sat      : set once cnt reaches all-ones, cleared only by clr or reset
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_d;
  logic             sat_d;

  // Next count / flag.
  always_comb begin
    cnt_d = cnt;
    sat_d = sat;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
      sat_d = 1'b0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt_d = cnt + CNT_W'(1);
      sat_d = (cnt_d == CNT_MAX);
    end
  end

  // Count / flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_d;
      sat <= sat_d;
    end
  end

endmodule

// File: rtl/seq_pattern_det.sv
// Run-time programmable serial bit-pattern detector. Accepted bits shift into
// a history register; when the newest len_r bits equal pat_r[len_r-1:0]
// (oldest bit against pat_r[len_r-1]) z pulses for one cycle on the next clock.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   x, x_vld            : serial data bit and its qualifier
//   cfg_ld              : strobe loading cfg_pat / cfg_len / cfg_ovl
//   cfg_pat             : pattern, bit [len-1] is the first bit received
//   cfg_len             : effective length, clamped into 1..PAT_W
//   cfg_ovl             : 1 = overlapping matches allowed
//   clr_cnt             : clear match counter
//   z                   : registered match pulse
//   match_cnt, cnt_sat  : saturating match count and sticky saturation flag
module seq_pattern_det #(
  parameter int unsigned      PAT_W   = 8,
  parameter int unsigned      LEN_W   = $clog2(PAT_W + 1),
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_det_pkg::DEF_PAT),
  parameter int unsigned      DEF_LEN = seq_det_pkg::DEF_LEN,
  parameter bit               DEF_OVL = seq_det_pkg::DEF_OVL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_vld,
  input  logic             cfg_ld,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  import seq_det_pkg::*;

  // Configuration registers.
  logic [PAT_W-1:0] pat_r, pat_d;
  logic [LEN_W-1:0] len_r, len_d;
  logic             ovl_r, ovl_d;

  // History: only PAT_W-1 bits need storing; the incoming bit completes
  // the PAT_W-wide comparison window.
  logic [PAT_W-2:0] hist, hist_d;
  logic [LEN_W-1:0] fill, fill_d;

  logic [PAT_W-1:0] shift_c;
  logic [LEN_W-1:0] fill_inc_c;
  logic [PAT_W:0]   one_sh_c;
  logic [PAT_W-1:0] len_mask_c;
  logic             match_c;
  det_state_e       state;

  // Mask selecting the low len_r bits of the window.
  assign one_sh_c   = (PAT_W + 1)'(1) << len_r;
  assign len_mask_c = PAT_W'(one_sh_c - (PAT_W + 1)'(1));

  // Fill level saturates at len_r so a full window keeps matching each bit.
  assign shift_c    = {hist, x};
  assign fill_inc_c = (fill < len_r) ? (fill + LEN_W'(1)) : len_r;

  // Progress decoded from the fill level.
  always_comb begin
    state = FILL;
    if (fill == '0) begin
      state = IDLE;
    end else if (fill == len_r) begin
      state = ARMED;
    end
  end

  // Next-state: configuration load wins over data, discarding the bit.
  always_comb begin
    pat_d   = pat_r;
    len_d   = len_r;
    ovl_d   = ovl_r;
    hist_d  = hist;
    fill_d  = fill;
    match_c = 1'b0;
    if (cfg_ld) begin
      pat_d  = cfg_pat;
      len_d  = LEN_W'(clamp_len(32'(cfg_len), PAT_W));
      ovl_d  = cfg_ovl;
      hist_d = '0;
      fill_d = '0;
    end else if (x_vld) begin
      hist_d  = shift_c[PAT_W-2:0];
      fill_d  = fill_inc_c;
      match_c = (fill_inc_c == len_r) &&
                (((shift_c ^ pat_r) & len_mask_c) == '0);
      // Non-overlapping: the next match must be built from fresh bits.
      if (match_c && !ovl_r) begin
        hist_d = '0;
        fill_d = '0;
      end
    end
  end

  // State, configuration and match-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_r <= DEF_PAT;
      len_r <= LEN_W'(DEF_LEN);
      ovl_r <= DEF_OVL;
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
    end else begin
      pat_r <= pat_d;
      len_r <= len_d;
      ovl_r <= ovl_d;
      hist  <= hist_d;
      fill  <= fill_d;
      z     <= match_c;
    end
  end

  // Structural invariants: fill never overruns the window, and a match from
  // an empty history is only possible for a single-bit pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (fill <= len_r);
      assert (!match_c || (state != IDLE) || (len_r == LEN_W'(1)));
    end
  end

  // Match counter.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match_c),
    .clr(clr_cnt),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );

endmodule

// File: tb/tb_seq_pattern_det.sv
// Scoreboard bench for seq_pattern_det: the driver runs a queue-based window
// model per issued cycle and pushes the expected outputs; a monitor pops and
// compares one entry per clock, and also drains directed checks.
module tb_seq_pattern_det;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk     = 1'b0;
  logic             rst     = 1'b0;
  logic             x       = 1'b0;
  logic             x_vld   = 1'b0;
  logic             cfg_ld  = 1'b0;
  logic [PAT_W-1:0] cfg_pat = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_ovl = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  seq_pattern_det #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .x(x),
    .x_vld(x_vld),
    .cfg_ld(cfg_ld),
    .cfg_pat(cfg_pat),
    .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl),
    .clr_cnt(clr_cnt),
    .z(z),
    .match_cnt(match_cnt),
    .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             z;
    logic [CNT_W-1:0] cnt;
    logic             sat;
  } exp_t;

  typedef struct {
    string nm;
    int    act;
    int    exp;
  } dchk_t;

  exp_t  sb[$];
  dchk_t dq[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model state: the accepted bits since the last clear.
  bit         win[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt;
  bit         m_sat;

  task automatic model_reset();
    m_pat = 8'b0001_0010;
    m_len = 5;
    m_ovl = 1'b1;
    win.delete();
    m_cnt = 0;
    m_sat = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    dchk_t d;
    d.nm  = nm;
    d.act = act;
    d.exp = exp;
    dq.push_back(d);
  endtask

  // Drive one cycle at the falling edge and queue the expected outputs.
  task automatic step(input bit b, input bit v, input bit ld = 1'b0,
                      input logic [7:0] p = 8'h00, input logic [3:0] l = 4'h0,
                      input bit o = 1'b0, input bit clr = 1'b0);
    exp_t e;
    bit   hit;
    @(negedge clk);
    x       = b;
    x_vld   = v;
    cfg_ld  = ld;
    cfg_pat = p;
    cfg_len = l;
    cfg_ovl = o;
    clr_cnt = clr;
    hit = 1'b0;
    if (ld) begin
      m_pat = p;
      m_len = (l == 4'd0) ? 1 : ((l > 4'd8) ? 8 : int'(l));
      m_ovl = o;
      win.delete();
    end else if (v) begin
      win.push_back(b);
      if (win.size() > m_len) void'(win.pop_front());
      if (win.size() == m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (win[i] != m_pat[m_len-1-i]) hit = 1'b0;
      end
      if (hit && !m_ovl) win.delete();
    end
    if (clr) begin
      m_cnt = hit ? 1 : 0;
      m_sat = 1'b0;
    end else if (hit && m_cnt < 255) begin
      m_cnt++;
      if (m_cnt == 255) m_sat = 1'b1;
    end
    e.z   = hit;
    e.cnt = 8'(m_cnt);
    e.sat = m_sat;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit o);
    step(1'b0, 1'b0, 1'b1, p, l, o, 1'b1);
  endtask

  // Send n bits (bits[n-1] first), checking z after each against zexp.
  task automatic run(input string nm, input logic [15:0] bits, input int n,
                     input logic [15:0] zexp);
    for (int k = n - 1; k >= 0; k--) begin
      step(bits[k], 1'b1);
      #2;
      chk(nm, int'(z), int'(zexp[k]));
    end
  endtask

  always begin : monitor
    exp_t  e;
    dchk_t d;
    @(posedge clk);
    #2;
    if (rst && sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if ({z, match_cnt, cnt_sat} !== e) begin
        bad++;
        $display("FAIL sb_out: got z=%0b cnt=%0d sat=%0b want z=%0b cnt=%0d sat=%0b",
                 z, match_cnt, cnt_sat, e.z, e.cnt, e.sat);
      end
    end
    while (dq.size() > 0) begin
      d = dq.pop_front();
      total++;
      if (d.act != d.exp) begin
        bad++;
        $display("FAIL %s: got %0d want %0d", d.nm, d.act, d.exp);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_z", int'(z), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    chk("rst_sat", int'(cnt_sat), 0);
    @(negedge clk);
    rst = 1'b1;

    // Defaults after reset.
    run("def_z", 16'b10010, 5, 16'b00001);
    chk("def_cnt", int'(match_cnt), 1);

    // Overlapping.
    cfg(8'h12, 4'd5, 1'b1);
    run("ovl_z", 16'b1001_0010, 8, 16'b0000_1001);
    chk("ovl_cnt", int'(match_cnt), 2);

    // Non-overlapping.
    cfg(8'h12, 4'd5, 1'b0);
    run("novl_z", 16'b1001_0010, 8, 16'b0000_1000);
    chk("novl_cnt", int'(match_cnt), 1);
    run("novl2_z", 16'b010, 3, 16'b001);
    chk("novl2_cnt", int'(match_cnt), 2);

    // Stalls inside an 8-bit pattern.
    cfg(8'hA5, 4'd8, 1'b1);
    run("stall_a_z", 16'b1010, 4, 16'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), 1'b0);
      #2;
      chk("stall_gap_z", int'(z), 0);
    end
    run("stall_b_z", 16'b0101, 4, 16'b0001);
    chk("stall_cnt", int'(match_cnt), 1);

    // Config load with a valid bit in the same cycle: bit discarded.
    step(1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0);
    #2;
    chk("ld_vld_z", int'(z), 0);
    run("ld_next_z", 16'b1, 1, 16'b1);

    // Length clamp 0 -> 1.
    cfg(8'h01, 4'd0, 1'b1);
    run("clamp_z", 16'b1101, 4, 16'b1101);
    chk("clamp_cnt", int'(match_cnt), 3);

    // Saturation then clear with simultaneous match.
    cfg(8'h01, 4'd1, 1'b1);
    repeat (260) step(1'b1, 1'b1);
    #2;
    chk("sat_cnt", int'(match_cnt), 255);
    chk("sat_flag", int'(cnt_sat), 1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1);
    #2;
    chk("clr_hit_cnt", int'(match_cnt), 1);
    chk("clr_hit_sat", int'(cnt_sat), 0);

    // Randomized traffic, biased toward the programmed pattern.
    for (int blk = 0; blk < 12; blk++) begin
      logic [7:0] p;
      logic [3:0] l;
      int         pos;
      p = 8'($urandom);
      l = (blk % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      cfg(p, l, 1'($urandom_range(0, 1)));
      pos = m_len - 1;
      for (int i = 0; i < 200; i++) begin
        bit b, v, c, ld;
        v  = ($urandom_range(0, 3) != 0);
        b  = ($urandom_range(0, 7) == 0) ? 1'($urandom) : m_pat[pos];
        c  = ($urandom_range(0, 63) == 0);
        ld = ($urandom_range(0, 199) == 0);
        if (ld) step(b, v, 1'b1, 8'($urandom), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), c);
        else    step(b, v, 1'b0, 8'h00, 4'h0, 1'b0, c);
        if (v) pos = (pos == 0) ? m_len - 1 : pos - 1;
        if (ld) pos = m_len - 1;
      end
    end

    // Asynchronous reset mid-stream while z is high.
    cfg(8'h01, 4'd1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    #2;
    chk("pre_rst_z", int'(z), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_z", int'(z), 0);
    chk("arst_cnt", int'(match_cnt), 0);
    chk("arst_sat", int'(cnt_sat), 0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run("post_rst_z", 16'b10010, 5, 16'b00001);
    chk("post_rst_cnt", int'(match_cnt), 1);

    step(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    repeat (2) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
